// File: rtl/jtag_user_dr.sv
// JTAG user data registers (ER1/ER2) with capture/shift/update shadows; updates land on the jtck edge sampling jupdate.
// Define JTAG_USER_DR_LENCHK_EN to reject updates whose shifted bit count differs from WIDTH.
module jtag_user_dr #(
    parameter int WIDTH = 32,
    parameter int NCHAN = 2
) (
    input  logic                   jtck,
    input  logic                   jrstn,
    input  logic                   jtdi,
    input  logic                   jshift,
    input  logic                   jupdate,
    input  logic [NCHAN-1:0]       jce,
    input  logic [NCHAN-1:0]       jrti,
    input  logic [NCHAN*WIDTH-1:0] din,
    output logic [NCHAN-1:0]       jtdo,
    output logic [NCHAN*WIDTH-1:0] dout,
    output logic [NCHAN-1:0]       upd,
    output logic [NCHAN-1:0]       rti,
    output logic [NCHAN-1:0]       lenerr
);

    // Lowest-numbered enabled channel wins when several jce bits are high.
    logic [NCHAN-1:0] ce_win;
    logic             any_cap;
    logic             upd_ok;

    assign ce_win  = jce & (~jce + NCHAN'(1));
    assign any_cap = (|jce) & ~jshift;
    assign upd_ok  = jupdate & (jce == '0);

    for (genvar i = 0; i < NCHAN; i++) begin : g_ch
        logic [WIDTH-1:0] sr_q, sr_d;
        logic [WIDTH-1:0] dout_q, dout_d;
        logic             sel_q, sel_d;
        logic             upd_q, upd_d;
        logic             jrti_q;
`ifdef JTAG_USER_DR_LENCHK_EN
        localparam int CNT_W = $clog2(WIDTH + 2);
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             lenerr_q, lenerr_d;
`endif

        always_comb begin
            sr_d   = sr_q;
            dout_d = dout_q;
            sel_d  = sel_q;
            upd_d  = 1'b0;
`ifdef JTAG_USER_DR_LENCHK_EN
            cnt_d    = cnt_q;
            lenerr_d = lenerr_q;
`endif
            if (ce_win[i] && !jshift) begin
                sr_d  = din[i*WIDTH +: WIDTH];
                sel_d = 1'b1;
`ifdef JTAG_USER_DR_LENCHK_EN
                cnt_d = '0;
`endif
            end else if (ce_win[i]) begin
                sr_d = {jtdi, sr_q[WIDTH-1:1]};
`ifdef JTAG_USER_DR_LENCHK_EN
                if (cnt_q != CNT_W'(WIDTH + 1))
                    cnt_d = cnt_q + CNT_W'(1);
`endif
            end else begin
                if (any_cap)
                    sel_d = 1'b0;
                if (upd_ok && sel_q) begin
                    sel_d = 1'b0;
`ifdef JTAG_USER_DR_LENCHK_EN
                    if (cnt_q == CNT_W'(WIDTH)) begin
                        dout_d   = sr_q;
                        upd_d    = 1'b1;
                        lenerr_d = 1'b0;
                    end else begin
                        lenerr_d = 1'b1;
                    end
`else
                    dout_d = sr_q;
                    upd_d  = 1'b1;
`endif
                end
            end
        end

        always_ff @(posedge jtck or negedge jrstn) begin
            if (!jrstn) begin
                sr_q   <= '0;
                dout_q <= '0;
                sel_q  <= 1'b0;
                upd_q  <= 1'b0;
                jrti_q <= 1'b0;
`ifdef JTAG_USER_DR_LENCHK_EN
                cnt_q    <= '0;
                lenerr_q <= 1'b0;
`endif
            end else begin
                sr_q   <= sr_d;
                dout_q <= dout_d;
                sel_q  <= sel_d;
                upd_q  <= upd_d;
                jrti_q <= jrti[i];
`ifdef JTAG_USER_DR_LENCHK_EN
                cnt_q    <= cnt_d;
                lenerr_q <= lenerr_d;
`endif
            end
        end

        assign jtdo[i]                 = sr_q[0];
        assign dout[i*WIDTH +: WIDTH]  = dout_q;
        assign upd[i]                  = upd_q;
        // Gated by jrstn so a held jrti cannot strobe while in reset.
        assign rti[i]                  = jrti[i] & ~jrti_q & jrstn;
`ifdef JTAG_USER_DR_LENCHK_EN
        assign lenerr[i]               = lenerr_q;
`else
        assign lenerr[i]               = 1'b0;
`endif
    end

endmodule
